// File: rtl/pb_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : pb_addr_gen
//  Brief    : HPGP turbo interleaver RAM address generator. Sequences a write
//             phase and a read phase per PHY block, with stall/abort support.
//  Revision : 1.0  initial release
// ============================================================================
module pb_addr_gen #(
    parameter int                ADDR_W  = 12,
    parameter logic [ADDR_W-1:0] LEN_16  = 12'h040,
    parameter logic [ADDR_W-1:0] LEN_136 = 12'h220,
    parameter logic [ADDR_W-1:0] LEN_520 = 12'h820,
    parameter logic [ADDR_W-1:0] OFF_16  = 12'h000,
    parameter logic [ADDR_W-1:0] OFF_136 = 12'h040,
    parameter logic [ADDR_W-1:0] OFF_520 = 12'h260
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] len_l,
    input  logic              abort,
    input  logic              din_vld,
    input  logic              dout_rdy,
    output logic [ADDR_W-1:0] enable,
    output logic [ADDR_W-1:0] pb_offset,
    output logic              wen,
    output logic              dout_vld,
    output logic              busy,
    output logic              len_err,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_TURN  = 2'd2,
        S_READ  = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0] r_last, w_last_nxt;
    logic [ADDR_W-1:0] r_pb_offset, w_pb_offset_nxt;
    logic              r_len_err, w_len_err_nxt;
    logic              r_done, w_done_nxt;

    logic              w_len_ok;
    logic [ADDR_W-1:0] w_sel_off;
    logic              w_cnt_last;

    // Map the requested length onto its RAM partition.
    always_comb begin
        w_len_ok  = 1'b1;
        w_sel_off = OFF_16;
        if (len_l == LEN_16) begin
            w_sel_off = OFF_16;
        end else if (len_l == LEN_136) begin
            w_sel_off = OFF_136;
        end else if (len_l == LEN_520) begin
            w_sel_off = OFF_520;
        end else begin
            w_len_ok = 1'b0;
        end
    end

    assign w_cnt_last = (r_cnt == r_last);

    assign wen       = (r_state == S_WRITE) && din_vld && !abort;
    assign dout_vld  = (r_state == S_READ) && !abort;
    assign busy      = (r_state != S_IDLE);
    assign enable    = r_cnt;
    assign pb_offset = r_pb_offset;
    assign len_err   = r_len_err;
    assign done      = r_done;

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_last_nxt      = r_last;
        w_pb_offset_nxt = r_pb_offset;
        w_len_err_nxt   = 1'b0;
        w_done_nxt      = 1'b0;

        case (r_state)
            S_IDLE: begin
                // abort in IDLE only serves to suppress a coincident start
                if (start && !abort) begin
                    if (w_len_ok) begin
                        w_state_nxt     = S_WRITE;
                        w_last_nxt      = len_l - 1'b1;
                        w_pb_offset_nxt = w_sel_off;
                        w_cnt_nxt       = '0;
                    end else begin
                        w_len_err_nxt = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (din_vld) begin
                    if (w_cnt_last) begin
                        w_state_nxt = S_TURN;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            S_TURN: begin
                w_state_nxt = abort ? S_IDLE : S_READ;
            end
            S_READ: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (dout_rdy) begin
                    if (w_cnt_last) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_last      <= '0;
            r_pb_offset <= '0;
            r_len_err   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_last      <= w_last_nxt;
            r_pb_offset <= w_pb_offset_nxt;
            r_len_err   <= w_len_err_nxt;
            r_done      <= w_done_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pb_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pb_addr_gen
//  Brief    : Scoreboard bench for pb_addr_gen: stimulus queues expected
//             events, a negedge monitor pops and compares them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pb_addr_gen;

    logic        clk = 1'b0;
    logic        rst, start, abort, din_vld, dout_rdy;
    logic [11:0] len_l;
    logic [11:0] enable, pb_offset;
    logic        wen, dout_vld, busy, len_err, done;

    pb_addr_gen dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len_l    (len_l),
        .abort    (abort),
        .din_vld  (din_vld),
        .dout_rdy (dout_rdy),
        .enable   (enable),
        .pb_offset(pb_offset),
        .wen      (wen),
        .dout_vld (dout_vld),
        .busy     (busy),
        .len_err  (len_err),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  kind;   // 0 write, 1 read, 2 done, 3 len_err
        logic [11:0] addr;
        logic [11:0] off;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [1:0] k, input logic [11:0] a, input logic [11:0] o);
        exp_t e;
        e.kind = k;
        e.addr = a;
        e.off  = o;
        sb.push_back(e);
    endtask

    task automatic pop(input logic [1:0] k, input string name);
        exp_t got;
        got.kind = k;
        got.addr = enable;
        got.off  = pb_offset;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_%s: got %0h expected none at %0t", name, got, $time);
        end else begin
            chk(name, 32'(got), 32'(sb.pop_front()));
        end
    endtask

    // Monitor
    logic        prev_stall = 1'b0;
    logic [11:0] prev_en    = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (wen)                 pop(2'd0, "write");
            if (dout_vld && dout_rdy) pop(2'd1, "read");
            if (done)                pop(2'd2, "done");
            if (len_err)             pop(2'd3, "len_err");
            if (prev_stall && dout_vld) chk("stall_hold", 32'(enable), 32'(prev_en));
            prev_stall = dout_vld && !dout_rdy;
            prev_en    = enable;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input logic [11:0] off);
        chk("idle_enable",   32'(enable),    32'h0);
        chk("idle_offset",   32'(pb_offset), 32'(off));
        chk("idle_wen",      32'(wen),       32'h0);
        chk("idle_dout_vld", 32'(dout_vld),  32'h0);
        chk("idle_busy",     32'(busy),      32'h0);
        chk("idle_len_err",  32'(len_err),   32'h0);
        chk("idle_done",     32'(done),      32'h0);
    endtask

    // Issues start in the current cycle and runs one frame; returns at the
    // negedge of the done cycle (or of the first cycle after an abort/reset).
    task automatic frame(input logic [11:0] len, input logic [11:0] off,
                         input int din_pct, input int rdy_pct, input int exp_cyc,
                         input int stop_at, input bit kill_rst, input int busy_start_at);
        int c;
        bit fin;
        int nwr;
        bit full;
        full = (stop_at < 0) || kill_rst;
        nwr  = full ? int'(len) : stop_at;
        for (int i = 0; i < nwr; i++) push(2'd0, 12'(i), off);
        if (full) begin
            for (int i = 0; i < int'(len); i++) push(2'd1, 12'(i), off);
            push(2'd2, 12'h000, off);
        end
        start    = 1'b1;
        len_l    = len;
        din_vld  = 1'b1;
        dout_rdy = 1'b1;
        abort    = 1'b0;
        step();
        start = 1'b0;
        len_l = 12'h00a;
        c     = 0;
        fin   = 1'b0;
        while (!fin) begin
            din_vld  = (int'($urandom_range(99)) < din_pct);
            dout_rdy = (int'($urandom_range(99)) < rdy_pct);
            start    = (c == busy_start_at);
            if (c == stop_at) begin
                if (kill_rst) begin
                    rst = 1'b1;
                    sb.delete();
                    step();
                    step();
                    rst = 1'b0;
                    @(negedge clk);
                    check_idle(12'h000);
                end else begin
                    abort   = 1'b1;
                    din_vld = 1'b1;
                    @(negedge clk);
                    chk("abort_wen",      32'(wen),      32'h0);
                    chk("abort_dout_vld", 32'(dout_vld), 32'h0);
                    step();
                    abort   = 1'b0;
                    din_vld = 1'b0;
                    @(negedge clk);
                    chk("abort_busy",   32'(busy),      32'h0);
                    chk("abort_cnt",    32'(enable),    32'h0);
                    chk("abort_done",   32'(done),      32'h0);
                    chk("abort_offset", 32'(pb_offset), 32'(off));
                end
                fin = 1'b1;
            end else begin
                @(negedge clk);
                if (c == 0) begin
                    chk("start_busy",   32'(busy),      32'h1);
                    chk("start_offset", 32'(pb_offset), 32'(off));
                end
                if (busy_start_at >= 0 && c == busy_start_at + 1)
                    chk("busy_start_len_err", 32'(len_err), 32'h0);
                if (done) begin
                    if (exp_cyc >= 0) chk("done_cycle", 32'(c), 32'(exp_cyc));
                    chk("done_busy", 32'(busy), 32'h0);
                    fin = 1'b1;
                end else if (c > 20000) begin
                    total++;
                    bad++;
                    $display("FAIL frame_timeout: got no done after %0d cycles expected done", c);
                    fin = 1'b1;
                end else begin
                    step();
                    c++;
                end
            end
        end
        start    = 1'b0;
        din_vld  = 1'b0;
        dout_rdy = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; din_vld = 1'b0; dout_rdy = 1'b0;
        len_l = 12'h000;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        check_idle(12'h000);

        // PB16 at full rate
        step();
        frame(12'h040, 12'h000, 100, 100, 129, -1, 1'b0, -1);

        // PB136 with random stalls on both sides
        step();
        frame(12'h220, 12'h040, 50, 30, -1, -1, 1'b0, -1);

        // Unsupported length
        step();
        start = 1'b1; len_l = 12'h00a; din_vld = 1'b1;
        push(2'd3, 12'h000, 12'h040);
        step();
        start = 1'b0;
        @(negedge clk);
        chk("len_err_pulse",  32'(len_err),   32'h1);
        chk("len_err_busy",   32'(busy),      32'h0);
        chk("len_err_wen",    32'(wen),       32'h0);
        chk("len_err_dvld",   32'(dout_vld),  32'h0);
        chk("len_err_offset", 32'(pb_offset), 32'h040);
        step();
        din_vld = 1'b0;
        @(negedge clk);
        chk("len_err_clear", 32'(len_err), 32'h0);

        // Abort PB520 after 100 writes, then restart as PB136
        step();
        frame(12'h820, 12'h260, 100, 100, -1, 100, 1'b0, -1);
        step();
        frame(12'h220, 12'h040, 100, 100, 1089, -1, 1'b0, -1);

        // PB520 with an ignored mid-write start, then back-to-back PB16
        step();
        frame(12'h820, 12'h260, 100, 100, 4161, -1, 1'b0, 10);
        frame(12'h040, 12'h000, 100, 100, 129, -1, 1'b0, -1);

        // Reset mid-READ, then a fresh PB16 frame
        step();
        frame(12'h040, 12'h000, 100, 100, -1, 75, 1'b1, -1);
        frame(12'h040, 12'h000, 100, 100, 129, -1, 1'b0, -1);

        step();
        step();
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
